hex_ascii_serializer: RTL and testbench

Parametrised, sequential successor to the team's nibble-to-ASCII converter. It accepts one WIDTH-bit word per transaction and streams its hexadecimal text representation one ASCII character per cycle over a valid/ready interface. The output supports an optional "0x" prefix, optional CR/LF terminator, upper- or lowercase digits and per-word leading-zero suppression. The block sits between register/debug sources and the UART transmitter or character display path.

---
 rtl/hex_ascii_serializer.sv | 145 ++++++++++++++
 tb/tb_hex_ascii_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_ascii_serializer.sv
// Streams the hexadecimal text of one WIDTH-bit word per transaction, one ASCII
// character per cycle, with optional "0x" prefix, CR/LF and leading-zero suppression.
module hex_ascii_serializer #(
  parameter int WIDTH     = 32,
  parameter int UPPERCASE = 0,
  parameter int PREFIX    = 1,
  parameter int NEWLINE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_suppress,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NDIG = (WIDTH + 3) / 4;
  localparam int PW   = 4 * NDIG;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PFX0   = 3'd1,
    S_PFX1   = 3'd2,
    S_DIGITS = 3'd3,
    S_CR     = 3'd4,
    S_LF     = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] word, word_nxt, in_padded;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    char_nxt;
  logic          last_nxt;

  assign in_padded = PW'(in_data);

  function automatic logic [IW-1:0] start_index(input logic [PW-1:0] w, input logic sup);
    logic [IW-1:0] s;
    s = IW'(NDIG - 1);
    if (sup) begin
      s = '0;
      for (int i = 0; i < NDIG; i++) begin
        if (w[4*i +: 4] != 4'h0) s = IW'(i);
      end
    end
    return s;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [PW-1:0] w, input logic [IW-1:0] i);
    logic [PW-1:0] sh;
    sh = w >> {i, 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)           return 8'h30 + {4'h0, n};
    else if (UPPERCASE != 0) return 8'h37 + {4'h0, n};
    else                     return 8'h57 + {4'h0, n};
  endfunction

  // Next state, digit index and the character that will be presented next cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          word_nxt  = in_padded;
          idx_nxt   = start_index(in_padded, in_suppress);
          state_nxt = (PREFIX != 0) ? S_PFX0 : S_DIGITS;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PFX0: begin
        if (out_ready) state_nxt = S_PFX1;
        else           state_nxt = S_PFX0;
      end
      S_PFX1: begin
        if (out_ready) state_nxt = S_DIGITS;
        else           state_nxt = S_PFX1;
      end
      S_DIGITS: begin
        if (out_ready) begin
          if (idx == '0) state_nxt = (NEWLINE != 0) ? S_CR : S_IDLE;
          else           idx_nxt   = idx - IW'(1);
        end else begin
          state_nxt = S_DIGITS;
        end
      end
      S_CR: begin
        if (out_ready) state_nxt = S_LF;
        else           state_nxt = S_CR;
      end
      S_LF: begin
        if (out_ready) state_nxt = S_IDLE;
        else           state_nxt = S_LF;
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_PFX0:   char_nxt = 8'h30;
      S_PFX1:   char_nxt = 8'h78;
      S_DIGITS: char_nxt = hex_char(nibble_at(word_nxt, idx_nxt));
      S_CR:     char_nxt = 8'h0D;
      S_LF:     char_nxt = 8'h0A;
      default:  char_nxt = 8'h00;
    endcase

    last_nxt = (state_nxt == S_LF) ||
               ((NEWLINE == 0) && (state_nxt == S_DIGITS) && (idx_nxt == '0));
  end

  // State, latched word and registered outputs; reset wins over accept/transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      word      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      word      <= word_nxt;
      idx       <= idx_nxt;
      out_valid <= (state_nxt != S_IDLE);
      out_char  <= char_nxt;
      out_last  <= last_nxt;
      busy      <= (state_nxt != S_IDLE);
      in_ready  <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Randomized self-checking bench for hex_ascii_serializer across three builds,
// compared against a text-level reference model of the expected character stream.
module tb_hex_ascii_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid    [3];
  logic        in_ready    [3];
  logic        in_suppress [3];
  logic        out_valid   [3];
  logic        out_ready   [3];
  logic        out_last    [3];
  logic        busy        [3];
  logic [15:0] in_data     [3];
  logic [7:0]  out_char    [3];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  hex_ascii_serializer #(.WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_suppress(in_suppress[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_char(out_char[0]), .out_last(out_last[0]), .busy(busy[0]));

  hex_ascii_serializer #(.WIDTH(8), .UPPERCASE(1), .PREFIX(0), .NEWLINE(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][7:0]), .in_suppress(in_suppress[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_char(out_char[1]), .out_last(out_last[1]), .busy(busy[1]));

  hex_ascii_serializer #(.WIDTH(6), .UPPERCASE(0), .PREFIX(0), .NEWLINE(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][5:0]), .in_suppress(in_suppress[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_char(out_char[2]), .out_last(out_last[2]), .busy(busy[2]));

  function automatic int cfg_w(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 8 : 6);
  endfunction
  function automatic bit cfg_up(input int k); return (k == 1); endfunction
  function automatic bit cfg_pf(input int k); return (k == 0); endfunction
  function automatic bit cfg_nl(input int k); return (k == 0); endfunction

  // Reference: hex text of the word as a sequence of characters.
  task automatic build_expected(input int k, input logic [15:0] data, input logic sup);
    int d, nd, st, nib;
    exp_q.delete();
    d  = int'(data) & ((1 << cfg_w(k)) - 1);
    nd = (cfg_w(k) + 3) / 4;
    st = nd - 1;
    if (sup) while (st > 0 && ((d >> (4 * st)) & 15) == 0) st--;
    if (cfg_pf(k)) begin exp_q.push_back(8'h30); exp_q.push_back(8'h78); end
    for (int i = st; i >= 0; i--) begin
      nib = (d >> (4 * i)) & 15;
      if (nib < 10) exp_q.push_back(8'(48 + nib));
      else          exp_q.push_back(8'((cfg_up(k) ? 65 : 97) + nib - 10));
    end
    if (cfg_nl(k)) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
  endtask

  task automatic run_word(input int k, input logic [15:0] data, input logic sup,
                          input bit rnd, input bit poke, input int stop_after);
    int n, cyc;
    bit rdy;
    build_expected(k, data, sup);
    @(negedge clk);
    total++;
    if (in_ready[k] !== 1'b1) begin
      bad++; $display("FAIL accept_ready k=%0d got=%b want=1", k, in_ready[k]);
    end
    in_data[k] = data; in_suppress[k] = sup; in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    n = 0; cyc = 0;
    while (n < exp_q.size() && cyc < 300) begin
      total++;
      if (out_valid[k] !== 1'b1) begin
        bad++; $display("FAIL out_valid k=%0d idx=%0d got=%b want=1", k, n, out_valid[k]);
      end
      total++;
      if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
        bad++; $display("FAIL busy_word k=%0d busy=%b in_ready=%b want 1/0", k, busy[k], in_ready[k]);
      end
      if (out_valid[k] === 1'b1) begin
        total++;
        if (out_char[k] !== exp_q[n]) begin
          bad++; $display("FAIL char k=%0d data=%h idx=%0d got=%h want=%h", k, data, n, out_char[k], exp_q[n]);
        end
        total++;
        if (out_last[k] !== (n == exp_q.size() - 1)) begin
          bad++; $display("FAIL last k=%0d idx=%0d got=%b want=%b", k, n, out_last[k], (n == exp_q.size() - 1));
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready[k] = rdy;
      if (poke) begin
        if (cyc == 2) begin in_data[k] = ~data; in_valid[k] = 1'b1; end
        else in_valid[k] = 1'b0;
      end
      if (out_valid[k] === 1'b1 && rdy) n++;
      @(negedge clk);
      cyc++;
      if (stop_after > 0 && n == stop_after) return;
    end
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b0;
    total++;
    if (cyc >= 300) begin
      bad++; $display("FAIL timeout k=%0d transfers=%0d want=%0d", k, n, exp_q.size());
    end
    total++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      bad++; $display("FAIL idle_after k=%0d out_valid=%b in_ready=%b busy=%b want 0/1/0",
                      k, out_valid[k], in_ready[k], busy[k]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid[k] !== 1'b0 || out_char[k] !== 8'h00 || out_last[k] !== 1'b0 ||
          busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        bad++; $display("FAIL reset_state k=%0d v=%b c=%h l=%b b=%b r=%b want 0/00/0/0/1",
                        k, out_valid[k], out_char[k], out_last[k], busy[k], in_ready[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_full_rate;
    run_word(0, 16'h0A3F, 1'b0, 1'b0, 1'b0, 0);
    run_word(0, 16'h0A3F, 1'b1, 1'b0, 1'b0, 0);
    run_word(0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    run_word(0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    run_word(0, 16'hBEEF, 1'b0, 1'b1, 1'b1, 0);
    run_word(0, 16'h00C0, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_narrow;
    run_word(1, 16'h00FE, 1'b0, 1'b0, 1'b0, 0);
    run_word(1, 16'h0005, 1'b1, 1'b0, 1'b0, 0);
    run_word(2, 16'h003F, 1'b0, 1'b0, 1'b0, 0);
    run_word(2, 16'h000A, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_abort;
    run_word(0, 16'h1234, 1'b0, 1'b0, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL abort_state out_valid=%b busy=%b in_ready=%b want 0/0/1",
                      out_valid[0], busy[0], in_ready[0]);
    end
    run_word(0, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 15; t++) begin
      run_word(int'($urandom_range(0, 2)), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_suppress[k] = 1'b0; in_data[k] = 16'h0000; out_ready[k] = 1'b1;
    end
    test_reset;
    test_full_rate;
    test_backpressure;
    test_narrow;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
